id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly downstream of the main/ALU decode logic.
- Captures the decoded control bundle, the operand data and the register indices for the Execute stage.
- Detects load-use hazards against the instruction currently in Execute and inserts bubbles on a hazard or on a branch flush.
- Drives the Fetch/Decode stall lines and keeps a saturating stall-event counter.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register index width.
- CNT_W, 16, width of the stall-event counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ValidD  in  1  Decode holds a real instruction
- RegWriteD  in  1  decoded register write enable
- ResultSrcD  in  2  00 = ALU, 01 = memory (load), 10 = PC+4
- MemWriteD  in  1  decoded store
- BranchD  in  1  decoded branch
- ALUSrcD  in  1  0 = RD2, 1 = immediate
- ALUOpD  in  2  ALU operation class
- funct3D  in  3  instruction funct3
- funct7b5D  in  1  instruction bit 30
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  operand, immediate and PC data
- Rs1D, Rs2D, RdD  in  RA_W each  register indices
- PCSrcE  in  1  branch taken in Execute; flush request
- *E outputs  out  same widths as the *D inputs above  registered copies (ValidE, RegWriteE, ..., RdE)
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallCount  out  CNT_W  number of load-use stall cycles

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - every *E output = 0, including ValidE = 0 and ResultSrcE = 00.
  - StallCount = 0.
  - StallF and StallD are therefore 0.
- lwStall (combinational) = ValidD & ValidE & (ResultSrcE == 01) & (RdE != 0) & ((Rs1D == RdE) | (Rs2D == RdE)).
  - Over-stalling on an unused Rs2 is accepted.
- StallF = StallD = lwStall & ~PCSrcE.
  - A taken branch squashes the Decode instruction, so no stall is requested.
- Bubble condition = PCSrcE | lwStall. On a clock edge with bubble:
  - ValidE, RegWriteE, MemWriteE, BranchE, ALUSrcE = 0; ResultSrcE = 00; ALUOpE = 00.
  - All data and index outputs = 0.
- No-bubble edge: every *E output takes the corresponding *D value. Latency is 1 cycle.
- ValidD = 0 with no bubble: fields are captured as-is, and ValidE = 0 marks them inert.
  - Invariant: ValidE = 0 implies RegWriteE = MemWriteE = BranchE = 0. Gate these three with ValidD on capture.
- Load-use duration: a load-use hazard stalls exactly one cycle.
  - The bubble clears ValidE, so lwStall deasserts on the next cycle.
  - The held Decode instruction is then captured.
- Simultaneous PCSrcE and lwStall: bubble; StallF = StallD = 0; StallCount does not increment.
- StallCount:
  - Increments by 1 on each edge where StallD = 1.
  - Saturates at 2^CNT_W - 1 (no wrap).
- No other state: the block has no FSM beyond the pipeline register and the counter.
- Reset mid-stall: all outputs clear immediately.
  - After release, the first edge captures the current D inputs normally.

Test Plan:
- Reset then release, ValidD = 1, R-type (RegWriteD = 1, ALUOpD = 10, RdD = 5, RD1D = 0x11) -> next edge RegWriteE = 1, ALUOpE = 10, RdE = 5, RD1E = 0x11; StallF = 0.
- Load in E (ResultSrcE = 01, RdE = 6) and D with Rs1D = 6 -> StallF = StallD = 1 for one cycle; following edge ValidE = 0, RegWriteE = 0; next edge captures the D instruction; StallCount = 1.
- Load in E with RdE = 0 and Rs1D = 0 -> no stall; StallCount stays 0.
- PCSrcE = 1 while D holds a store (MemWriteD = 1) -> MemWriteE = 0, ValidE = 0; StallF = 0.
- PCSrcE = 1 together with a load-use match -> bubble, StallF = StallD = 0, StallCount unchanged.
- CNT_W = 2 with 5 back-to-back load-use pairs -> StallCount reaches 3 and holds.
- Assert rst_n = 0 asynchronously mid-cycle during a stall -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush bubbles
// and a saturating counter of load-use stall cycles.
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RA_W  = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ValidD,
   input  logic             RegWriteD,
   input  logic [1:0]       ResultSrcD,
   input  logic             MemWriteD,
   input  logic             BranchD,
   input  logic             ALUSrcD,
   input  logic [1:0]       ALUOpD,
   input  logic [2:0]       funct3D,
   input  logic             funct7b5D,
   input  logic [XLEN-1:0]  RD1D,
   input  logic [XLEN-1:0]  RD2D,
   input  logic [XLEN-1:0]  ImmExtD,
   input  logic [XLEN-1:0]  PCD,
   input  logic [XLEN-1:0]  PCPlus4D,
   input  logic [RA_W-1:0]  Rs1D,
   input  logic [RA_W-1:0]  Rs2D,
   input  logic [RA_W-1:0]  RdD,
   input  logic             PCSrcE,
   output logic             ValidE,
   output logic             RegWriteE,
   output logic [1:0]       ResultSrcE,
   output logic             MemWriteE,
   output logic             BranchE,
   output logic             ALUSrcE,
   output logic [1:0]       ALUOpE,
   output logic [2:0]       funct3E,
   output logic             funct7b5E,
   output logic [XLEN-1:0]  RD1E,
   output logic [XLEN-1:0]  RD2E,
   output logic [XLEN-1:0]  ImmExtE,
   output logic [XLEN-1:0]  PCE,
   output logic [XLEN-1:0]  PCPlus4E,
   output logic [RA_W-1:0]  Rs1E,
   output logic [RA_W-1:0]  Rs2E,
   output logic [RA_W-1:0]  RdE,
   output logic             StallF,
   output logic             StallD,
   output logic [CNT_W-1:0] StallCount
);

   logic lw_stall;
   logic bubble;
   logic stall;

   always_comb begin
      lw_stall = ValidD & ValidE & (ResultSrcE == 2'b01) & (RdE != '0) &
                 ((Rs1D == RdE) | (Rs2D == RdE));
      // a taken branch squashes Decode, so holding it would be pointless
      stall    = lw_stall & ~PCSrcE;
      bubble   = PCSrcE | lw_stall;
   end

   assign StallF = stall;
   assign StallD = stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ValidE     <= 1'b0;
         RegWriteE  <= 1'b0;
         ResultSrcE <= '0;
         MemWriteE  <= 1'b0;
         BranchE    <= 1'b0;
         ALUSrcE    <= 1'b0;
         ALUOpE     <= '0;
         funct3E    <= '0;
         funct7b5E  <= 1'b0;
         RD1E       <= '0;
         RD2E       <= '0;
         ImmExtE    <= '0;
         PCE        <= '0;
         PCPlus4E   <= '0;
         Rs1E       <= '0;
         Rs2E       <= '0;
         RdE        <= '0;
      end else if (bubble) begin
         ValidE     <= 1'b0;
         RegWriteE  <= 1'b0;
         ResultSrcE <= '0;
         MemWriteE  <= 1'b0;
         BranchE    <= 1'b0;
         ALUSrcE    <= 1'b0;
         ALUOpE     <= '0;
         funct3E    <= '0;
         funct7b5E  <= 1'b0;
         RD1E       <= '0;
         RD2E       <= '0;
         ImmExtE    <= '0;
         PCE        <= '0;
         PCPlus4E   <= '0;
         Rs1E       <= '0;
         Rs2E       <= '0;
         RdE        <= '0;
      end else begin
         // side-effecting controls are gated so an inert slot can never write
         ValidE     <= ValidD;
         RegWriteE  <= RegWriteD & ValidD;
         ResultSrcE <= ResultSrcD;
         MemWriteE  <= MemWriteD & ValidD;
         BranchE    <= BranchD & ValidD;
         ALUSrcE    <= ALUSrcD;
         ALUOpE     <= ALUOpD;
         funct3E    <= funct3D;
         funct7b5E  <= funct7b5D;
         RD1E       <= RD1D;
         RD2E       <= RD2D;
         ImmExtE    <= ImmExtD;
         PCE        <= PCD;
         PCPlus4E   <= PCPlus4D;
         Rs1E       <= Rs1D;
         Rs2E       <= Rs2D;
         RdE        <= RdD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         StallCount <= '0;
      else if (stall && (StallCount != '1))
         StallCount <= StallCount + CNT_W'(1);
   end

endmodule
